// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer driving the register file commit port
module reorder_buffer #(
    parameter int RobDepth = 8,
    parameter int PtrWidth = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [31:0]         issue_pc,
    input  logic [4:0]          issue_rd,
    input  logic                wb_valid,
    input  logic [31:0]         wb_pc,
    input  logic [31:0]         wb_data,
    input  logic                wb_mispredict,
    input  logic [31:0]         wb_target,
    output logic                is_stall_to_rf,
    output logic                is_finish_to_rf,
    output logic                is_exception_to_rf,
    output logic [4:0]          rd_to_rf,
    output logic [31:0]         pc_to_rf,
    output logic [31:0]         data_to_rf,
    output logic [31:0]         target_pc_to_fetch,
    output logic [PtrWidth:0]   count
);

    localparam logic [PtrWidth:0] CountFull = (PtrWidth+1)'(RobDepth);
    localparam logic [PtrWidth:0] CountOne  = (PtrWidth+1)'(1);

    logic [RobDepth-1:0] ent_valid_q, ent_valid_d;
    logic [RobDepth-1:0] ent_ready_q, ent_ready_d;
    logic [RobDepth-1:0] ent_mis_q, ent_mis_d;
    logic [31:0]         ent_pc_q     [RobDepth];
    logic [31:0]         ent_pc_d     [RobDepth];
    logic [4:0]          ent_rd_q     [RobDepth];
    logic [4:0]          ent_rd_d     [RobDepth];
    logic [31:0]         ent_data_q   [RobDepth];
    logic [31:0]         ent_data_d   [RobDepth];
    logic [31:0]         ent_target_q [RobDepth];
    logic [31:0]         ent_target_d [RobDepth];

    logic [PtrWidth-1:0] head_q, head_d, tail_q, tail_d;
    logic [PtrWidth:0]   count_q, count_d;

    logic        finish_q, finish_d, exception_q, exception_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic [31:0] pc_out_q, pc_out_d, data_out_q, data_out_d, target_out_q, target_out_d;

    logic                full, retire, flush, issue_ok, found;
    logic [PtrWidth-1:0] idx;

    always_comb begin
        ent_valid_d  = ent_valid_q;
        ent_ready_d  = ent_ready_q;
        ent_mis_d    = ent_mis_q;
        ent_pc_d     = ent_pc_q;
        ent_rd_d     = ent_rd_q;
        ent_data_d   = ent_data_q;
        ent_target_d = ent_target_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        finish_d     = 1'b0;
        exception_d  = 1'b0;
        rd_out_d     = rd_out_q;
        pc_out_d     = pc_out_q;
        data_out_d   = data_out_q;
        target_out_d = target_out_q;
        found        = 1'b0;
        idx          = '0;

        full     = (count_q == CountFull);
        retire   = ent_valid_q[head_q] && ent_ready_q[head_q];
        flush    = retire && ent_mis_q[head_q];
        issue_ok = issue_valid && !full && !flush;

        if (retire) begin
            finish_d    = !ent_mis_q[head_q];
            exception_d = ent_mis_q[head_q];
            rd_out_d    = ent_rd_q[head_q];
            pc_out_d    = ent_pc_q[head_q];
            data_out_d  = ent_data_q[head_q];
        end

        if (flush) begin
            // Everything younger than the branch is wrong-path; issue and writeback are dropped.
            target_out_d = ent_target_q[head_q];
            ent_valid_d  = '0;
            ent_ready_d  = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
        end else begin
            if (retire) begin
                ent_valid_d[head_q] = 1'b0;
                head_d              = head_q + PtrWidth'(1);
            end
            if (issue_ok) begin
                ent_valid_d[tail_q] = 1'b1;
                ent_ready_d[tail_q] = 1'b0;
                ent_mis_d[tail_q]   = 1'b0;
                ent_pc_d[tail_q]    = issue_pc;
                ent_rd_d[tail_q]    = issue_rd;
                tail_d              = tail_q + PtrWidth'(1);
            end
            // Scan from head so the oldest of several in-flight copies of a PC is matched first.
            if (wb_valid) begin
                for (int i = 0; i < RobDepth; i++) begin
                    idx = head_q + PtrWidth'(i);
                    if (!found && ent_valid_q[idx] && !ent_ready_q[idx] && ent_pc_q[idx] == wb_pc) begin
                        found             = 1'b1;
                        ent_ready_d[idx]  = 1'b1;
                        ent_data_d[idx]   = wb_data;
                        ent_mis_d[idx]    = wb_mispredict;
                        ent_target_d[idx] = wb_target;
                    end
                end
            end
            if (issue_ok && !retire) begin
                count_d = count_q + CountOne;
            end else if (!issue_ok && retire) begin
                count_d = count_q - CountOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid_q  <= '0;
            ent_ready_q  <= '0;
            ent_mis_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            finish_q     <= 1'b0;
            exception_q  <= 1'b0;
            rd_out_q     <= '0;
            pc_out_q     <= '0;
            data_out_q   <= '0;
            target_out_q <= '0;
        end else begin
            ent_valid_q  <= ent_valid_d;
            ent_ready_q  <= ent_ready_d;
            ent_mis_q    <= ent_mis_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            finish_q     <= finish_d;
            exception_q  <= exception_d;
            rd_out_q     <= rd_out_d;
            pc_out_q     <= pc_out_d;
            data_out_q   <= data_out_d;
            target_out_q <= target_out_d;
        end
    end

    // Payload is qualified by valid/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_pc_q     <= ent_pc_d;
        ent_rd_q     <= ent_rd_d;
        ent_data_q   <= ent_data_d;
        ent_target_q <= ent_target_d;
    end

    assign is_stall_to_rf     = (count_q == CountFull);
    assign is_finish_to_rf    = finish_q;
    assign is_exception_to_rf = exception_q;
    assign rd_to_rf           = rd_out_q;
    assign pc_to_rf           = pc_out_q;
    assign data_to_rf         = data_out_q;
    assign target_pc_to_fetch = target_out_q;
    assign count              = count_q;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer that drives the commit-side port of the register file (`rf`). It allocates one entry per issued instruction, collects out-of-order writebacks tagged by PC, and retires the oldest completed entry each cycle. On retire it drives the register file's finish, rd, pc and data inputs. On a mispredicted branch it raises exception and flushes every in-flight entry. While it is full it stalls issue.

## Interface
Parameters:
- `RobDepth`, 8: number of entries; power of two, at least 2.
- `PtrWidth`, 3: log2(`RobDepth`).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `issue_valid`  in  1  new instruction presented for allocation.
- `issue_pc`  in  32  PC of the issued instruction; used as the entry tag.
- `issue_rd`  in  5  destination register; 0 means no write.
- `wb_valid`  in  1  an execution unit reports a result.
- `wb_pc`  in  32  tag of the reported result.
- `wb_data`  in  32  result value.
- `wb_mispredict`  in  1  the reported instruction is a mispredicted branch.
- `wb_target`  in  32  correct next PC when `wb_mispredict` is 1.
- `is_stall_to_rf`  out  1  buffer full; issue is not accepted.
- `is_finish_to_rf`  out  1  one-cycle retire pulse.
- `is_exception_to_rf`  out  1  one-cycle flush pulse.
- `rd_to_rf`  out  5  retired destination register.
- `pc_to_rf`  out  32  retired tag.
- `data_to_rf`  out  32  retired value.
- `target_pc_to_fetch`  out  32  redirect PC; valid only while `is_exception_to_rf` is 1.
- `count`  out  PtrWidth+1  number of occupied entries.

## Operation
- **Storage:** circular array of `RobDepth` entries. Each entry holds valid, ready, mispredict, pc, rd, data and target.
- **Pointers:** `head` is the oldest entry, `tail` is the next free slot, and `count` is the occupancy. Both pointers wrap modulo `RobDepth`.
- **Stall:** `is_stall_to_rf` = (`count` == `RobDepth`). It is combinational from registered state.
- **Allocate:** when `issue_valid` is 1 and the buffer is not full, write {valid=1, ready=0, pc, rd} at `tail` and advance `tail`.
- **Writeback:**
  - When `wb_valid` is 1, match the oldest valid, not-ready entry whose pc equals `wb_pc`, searching from `head`. Duplicate PCs can be in flight in loops.
  - On a match, set ready=1 and latch data, mispredict and target.
  - With no match, the writeback is dropped and no state changes.
- **Retire:** when the head entry is valid and ready, and no flush is in progress:
  - If mispredict = 0: pulse `is_finish_to_rf`; drive rd, pc and data from the entry; clear valid; advance `head`.
  - If mispredict = 1: pulse `is_exception_to_rf` together with rd, pc, data and `target_pc_to_fetch`.
    - `is_finish_to_rf` stays 0 on this pulse.
    - On the same edge, clear every entry's valid, set `head` = `tail` = 0 and `count` = 0.
- **Retire rate:** at most one retire per cycle.
- **Count update:** `count` next = `count` + accepted issue − retire. Simultaneous accepted issue and retire leave `count` unchanged.
- **rd = 0:** the entry still retires normally. The register file itself ignores writes to x0.

## Timing
- **Reset:** while `rst` is 0 at an edge, all entries become invalid and `head`, `tail` and `count` become 0. All outputs are 0, including `is_stall_to_rf`. Reset overrides simultaneous issue, writeback and retire, including mid-flush.
- **Output registers:** retire outputs are registered. They are asserted for exactly one cycle after the edge that performs the retire. `rd`, `pc`, `data` and `target` hold their last value otherwise.
- **Writeback-to-retire latency:** a writeback sampled at edge E marks its entry ready. If that entry is head, it retires at edge E+1, so outputs are visible during cycle E+1..E+2. The minimum issue→retire time is therefore 2 edges.
- **Issue vs. writeback:** an entry allocated at edge E cannot be matched by a writeback sampled at that same edge E.
- **Full with retire:** when full and a retire occurs in the same cycle, issue is still rejected that cycle. The stall drops the following cycle.
- **Flush edge:** on the flush edge, the concurrent `issue_valid` and `wb_valid` are ignored. `is_stall_to_rf` is 0 in the next cycle.
- **Wrap-around:** `tail` going from `RobDepth`−1 to 0 while `head` is nonzero is normal operation. Full and empty are distinguished only by `count`.

## Test plan
- **Reset:** hold `rst`=0 for 2 edges with `issue_valid`=1 → `count`=0, `is_stall_to_rf`=0, all pulses 0.
- **In-order retire:** issue pc 0x100 (rd 5), 0x104 (rd 6), 0x108 (rd 7); write back in order 0x108=3, 0x100=1, 0x104=2. Expect `is_finish_to_rf` pulses in order (0x100, 5, 1), (0x104, 6, 2), (0x108, 7, 3) on consecutive cycles after 0x104's writeback.
- **Full and wrap:** issue 8 entries → `is_stall_to_rf`=1 and a 9th issue is rejected (`count` stays 8). Retire 1 while issuing → stall drops one cycle later. Then issue 12 more with retires → pointers wrap, retire order matches issue order.
- **Mispredict flush:** issue 0x200 (branch) and 0x204, 0x208. Write back 0x204, then 0x200 with mispredict and target 0x300 → a single `is_exception_to_rf` pulse with `target_pc_to_fetch`=0x300; `count`=0 next cycle; no finish pulse for 0x204 or 0x208.
- **Duplicate tags:** issue pc 0x400 twice (rd 1, rd 2); write back 0x400=9 → only the older entry is ready. Retire (0x400, 1, 9). A second writeback 0x400=10 → retire (0x400, 2, 10).
- **Mid-operation reset:** with 4 entries pending, assert `rst`=0 on the same edge as a retire and a writeback → no pulse next cycle, `count`=0.
